// File: rtl/fetch_stage.sv
// Instruction fetch: owns the pc, issues one imem request at a time, and holds ir/pc until execute accepts (>=3 cycles/insn).
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned targets into a sticky HALT; otherwise the low pc bits are masked.
module fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP_INSN = XLEN'(32'h0000_0013)
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ir,
  output logic [XLEN-1:0] pc,
  output logic            ir_valid,
  input  logic            ex_ready,
  input  logic [XLEN-1:0] imm,
  input  logic [1:0]      pc_sel,
  input  logic            br_taken,
  input  logic [XLEN-1:0] rs1_data,
  output logic            fetch_misaligned
);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [1:0] SEL_PC4    = 2'd0;
  localparam logic [1:0] SEL_BRANCH = 2'd1;
  localparam logic [1:0] SEL_JAL    = 2'd2;
  localparam logic [1:0] SEL_JALR   = 2'd3;

  logic [1:0]      state;
  logic            started;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] ir_q;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_tgt;
  logic [XLEN-1:0] next_pc;
  logic [XLEN-1:0] next_pc_aligned;
  logic            retire;

  assign pc_plus4        = pc_q + XLEN'(4);
  assign pc_plus_imm     = pc_q + imm;
  assign jalr_tgt        = (rs1_data + imm) & ~XLEN'(1);
  assign next_pc_aligned = next_pc & ~XLEN'(3);
  assign retire          = (state == ST_VALID) && ex_ready;

  always_comb begin
    next_pc = pc_plus4;
    unique case (pc_sel)
      SEL_PC4:    next_pc = pc_plus4;
      SEL_BRANCH: next_pc = br_taken ? pc_plus_imm : pc_plus4;
      SEL_JAL:    next_pc = pc_plus_imm;
      SEL_JALR:   next_pc = jalr_tgt;
      default:    next_pc = pc_plus4;
    endcase
  end

  // started keeps imem_req low while in reset and for the cycle reset is released in
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_REQ;
      started <= 1'b0;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
    end else begin
      started <= 1'b1;
      case (state)
        ST_REQ: begin
          if (started && imem_ready) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (imem_rvalid) begin
            ir_q  <= imem_rdata;
            state <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (retire) begin
`ifdef FETCH_MISALIGN_TRAP_EN
            if (next_pc[1:0] != 2'b00) begin
              pc_q  <= next_pc;
              state <= ST_HALT;
            end else begin
              pc_q  <= next_pc_aligned;
              state <= ST_REQ;
            end
`else
            pc_q  <= next_pc_aligned;
            state <= ST_REQ;
`endif
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        ST_HALT: state <= ST_HALT;
`endif
        default: state <= ST_REQ;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misaligned_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misaligned_q <= 1'b0;
    end else if (retire && (next_pc[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign fetch_misaligned = misaligned_q;
`else
  assign fetch_misaligned = 1'b0;
`endif

  assign imem_req  = started && (state == ST_REQ);
  assign imem_addr = pc_q;
  assign ir_valid  = (state == ST_VALID);
  assign ir        = ir_valid ? ir_q : NOP_INSN;
  assign pc        = pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        ir_valid;
  logic        ex_ready;
  logic [31:0] imm;
  logic [1:0]  pc_sel;
  logic        br_taken;
  logic [31:0] rs1_data;
  logic        fetch_misaligned;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 0;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ir(ir), .pc(pc), .ir_valid(ir_valid), .ex_ready(ex_ready),
    .imm(imm), .pc_sel(pc_sel), .br_taken(br_taken), .rs1_data(rs1_data),
    .fetch_misaligned(fetch_misaligned)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0=awaiting acceptance, 1=awaiting response, 2=holding insn, 3=halted
  int          m_phase;
  bit          m_started;
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  bit          m_mis;

  function automatic logic [31:0] model_next(input logic [31:0] cur, input logic [1:0] sel,
                                             input logic tk, input logic [31:0] im, input logic [31:0] r1);
    logic [31:0] t;
    case (sel)
      2'd0:    t = cur + 32'd4;
      2'd1:    t = tk ? cur + im : cur + 32'd4;
      2'd2:    t = cur + im;
      default: begin t = r1 + im; t = t - (t % 2); end
    endcase
    return t;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase   <= 0;
      m_started <= 0;
      m_pc      <= 32'h0;
      m_ir      <= NOP;
      m_mis     <= 0;
    end else begin
      logic [31:0] nxt;
      m_started <= 1;
      nxt = model_next(m_pc, pc_sel, br_taken, imm, rs1_data);
      if (m_phase == 0 && m_started && imem_ready) m_phase <= 1;
      else if (m_phase == 1 && imem_rvalid) begin
        m_ir    <= imem_rdata;
        m_phase <= 2;
      end else if (m_phase == 2 && ex_ready) begin
`ifdef FETCH_MISALIGN_TRAP_EN
        if (nxt % 4 != 0) begin
          m_pc    <= nxt;
          m_mis   <= 1;
          m_phase <= 3;
        end else begin
          m_pc    <= nxt - (nxt % 4);
          m_phase <= 0;
        end
`else
        m_pc    <= nxt - (nxt % 4);
        m_phase <= 0;
`endif
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      chk("m_req",   32'(imem_req), 32'(m_started && m_phase == 0));
      chk("m_addr",  imem_addr, m_pc);
      chk("m_valid", 32'(ir_valid), 32'(m_phase == 2));
      chk("m_ir",    ir, (m_phase == 2) ? m_ir : NOP);
      chk("m_pc",    pc, m_pc);
      chk("m_mis",   32'(fetch_misaligned), 32'(m_mis));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic fetch_one(input logic [31:0] insn);
    int n = 0;
    imem_ready = 1;
    while (!imem_req && n < 20) begin tick(); n++; end
    if (!imem_req) chk("fetch_req_timeout", 32'(imem_req), 32'd1);
    tick();
    imem_ready  = 0;
    imem_rvalid = 1;
    imem_rdata  = insn;
    tick();
    imem_rvalid = 0;
  endtask

  task automatic retire(input logic [1:0] sel, input logic tk, input logic [31:0] im, input logic [31:0] r1);
    pc_sel   = sel;
    br_taken = tk;
    imm      = im;
    rs1_data = r1;
    ex_ready = 1;
    tick();
    ex_ready = 0;
  endtask

  initial begin
    logic [31:0] r_imm;
    rst_n = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    ex_ready = 0; imm = 0; pc_sel = 0; br_taken = 0; rs1_data = 0;
    tick(); tick();
    cmp_en = 1;

    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_ir", ir, NOP);
    chk("rst_pc", pc, 32'h0);
    chk("rst_valid", 32'(ir_valid), 32'd0);
    chk("rst_mis", 32'(fetch_misaligned), 32'd0);

    // first fetch after reset release
    imem_ready = 1; ex_ready = 1; rst_n = 1;
    tick();
    chk("t1_req", 32'(imem_req), 32'd1);
    chk("t1_addr", imem_addr, 32'h0);
    tick();
    chk("t1_wait_req", 32'(imem_req), 32'd0);
    imem_rvalid = 1; imem_rdata = 32'h0010_0093;
    tick();
    imem_rvalid = 0;
    chk("t1_valid", 32'(ir_valid), 32'd1);
    chk("t1_ir", ir, 32'h0010_0093);
    chk("t1_pc", pc, 32'h0);
    tick();
    ex_ready = 0; imem_ready = 0;
    chk("t1_next_req", 32'(imem_req), 32'd1);
    chk("t1_next_addr", imem_addr, 32'h4);

    // branch taken / not taken from 0x100
    fetch_one(32'h1); retire(2'd2, 0, 32'h0000_00FC, 0);
    chk("br_setup", imem_addr, 32'h100);
    fetch_one(32'h2); retire(2'd1, 1, 32'hFFFF_FFF0, 0);
    chk("br_taken", imem_addr, 32'h0000_00F0);
    chk("model_br_taken", m_pc, 32'h0000_00F0);
    fetch_one(32'h3); retire(2'd2, 0, 32'h10, 0);
    fetch_one(32'h4); retire(2'd1, 0, 32'hFFFF_FFF0, 0);
    chk("br_not_taken", imem_addr, 32'h104);
    chk("model_br_not_taken", m_pc, 32'h104);

    // JALR clears bit 0
    fetch_one(32'h5); retire(2'd3, 0, 32'h4, 32'h2001);
    chk("jalr", imem_addr, 32'h2004);

    // stall in VALID with spurious rvalid
    fetch_one(32'h00A0_0113);
    for (int i = 0; i < 10; i++) begin
      imem_rvalid = (i % 3 == 0);
      imem_rdata  = $urandom;
      tick();
      chk("stall_ir", ir, 32'h00A0_0113);
      chk("stall_pc", pc, 32'h2004);
      chk("stall_valid", 32'(ir_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    imem_rvalid = 0;
    retire(2'd0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", imem_addr, 32'h2008);
    end

    // wrap-around
    fetch_one(32'h6); retire(2'd2, 0, 32'hFFFF_FFFC - 32'h2008, 0);
    chk("wrap_setup", imem_addr, 32'hFFFF_FFFC);
    fetch_one(32'h7); retire(2'd0, 0, 0, 0);
    chk("wrap", imem_addr, 32'h0);

    // reset while waiting for a response; late rvalid must be ignored
    imem_ready = 1;
    tick();
    imem_ready = 0;
    chk("rw_wait", 32'(imem_req), 32'd0);
    rst_n = 0;
    tick();
    chk("rw_rst_req", 32'(imem_req), 32'd0);
    rst_n = 1; imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 0;
    chk("rw_req", 32'(imem_req), 32'd1);
    chk("rw_addr", imem_addr, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rw_no_valid", 32'(ir_valid), 32'd0);
      chk("rw_ir_nop", ir, NOP);
    end
    fetch_one(32'h0000_0297);
    chk("rw_fresh_ir", ir, 32'h0000_0297);
    chk("rw_fresh_pc", pc, 32'h0);

    // misaligned JAL target
    retire(2'd2, 0, 32'h6, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag", 32'(fetch_misaligned), 32'd1);
    chk("mis_pc", pc, 32'h6);
    chk("mis_ir", ir, NOP);
    for (int i = 0; i < 3; i++) begin
      imem_ready = 1; ex_ready = 1; imem_rvalid = 1;
      tick();
      chk("mis_req", 32'(imem_req), 32'd0);
      chk("mis_valid", 32'(ir_valid), 32'd0);
    end
    imem_ready = 0; ex_ready = 0; imem_rvalid = 0;
`else
    chk("mask_addr", imem_addr, 32'h4);
    chk("mask_flag", 32'(fetch_misaligned), 32'd0);
`endif
    rst_n = 0;
    tick();
    rst_n = 1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst_n       = ($urandom_range(0, 399) != 0);
      imem_ready  = ($urandom_range(0, 9) < 7);
      imem_rvalid = ($urandom_range(0, 9) < 4) && !(m_started && m_phase == 0 && imem_ready);
      imem_rdata  = $urandom;
      ex_ready    = $urandom_range(0, 1) != 0;
      pc_sel      = 2'($urandom_range(0, 3));
      br_taken    = $urandom_range(0, 1) != 0;
      r_imm       = ($urandom_range(0, 63) << 2) - 32'd128;
      imm         = ($urandom_range(0, 15) == 0) ? $urandom : r_imm;
      rs1_data    = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      tick();
    end

    cmp_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly upstream of the decode/execute stage.
- Owns the program counter and issues one instruction-memory request at a time.
- Presents the fetched instruction (ir) and its pc to decode/execute and holds them until execute accepts.
- On acceptance, computes the next pc from the redirect information that decode/execute returns (imm, pc_sel, br_taken) plus rs1_data for JALR.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSN, 32'h0000_0013, instruction driven on ir whenever ir_valid=0 (addi x0,x0,0).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address.
- imem_ready  in  1  request accepted this cycle (imem_req & imem_ready).
- imem_rvalid  in  1  response data valid; never in the same cycle as acceptance.
- imem_rdata  in  XLEN  response instruction word.
- ir  out  XLEN  instruction to decode/execute.
- pc  out  XLEN  address of ir.
- ir_valid  out  1  ir/pc hold a real fetched instruction.
- ex_ready  in  1  execute consumes ir this cycle (retire).
- imm  in  XLEN  immediate from decode/execute.
- pc_sel  in  2  0=PC+4, 1=BRANCH, 2=JAL, 3=JALR.
- br_taken  in  1  branch condition true.
- rs1_data  in  XLEN  JALR base register value.
- fetch_misaligned  out  1  sticky misaligned-target flag (see Optional Feature).

Behaviour:
- Reset (rst_n=0, async):
  - state=REQ; pc_q=RESET_PC; ir_q=NOP_INSN.
  - Outputs: imem_req=0, imem_addr=RESET_PC, ir=NOP_INSN, pc=RESET_PC, ir_valid=0, fetch_misaligned=0.
  - imem_req goes high in the first clock after rst_n rises.
- States:
  - REQ: imem_req=1, imem_addr=pc_q; on imem_ready go to WAIT.
  - WAIT: imem_req=0; on imem_rvalid capture ir_q=imem_rdata and go to VALID.
  - VALID: ir_valid=1, ir=ir_q, pc=pc_q; on ex_ready set pc_q=next_pc and go to REQ.
  - HALT: only exists with the Optional Feature enabled.
- Outputs outside VALID: ir=NOP_INSN, ir_valid=0, pc=pc_q.
- next_pc, evaluated combinationally in the retire cycle, modulo 2^32 (carry discarded):
  - pc_sel=0: pc_q+4.
  - pc_sel=1: br_taken ? pc_q+imm : pc_q+4.
  - pc_sel=2: pc_q+imm.
  - pc_sel=3: (rs1_data+imm) & ~32'h1.
- Minimum throughput: 3 cycles per instruction (accept, rvalid, retire). Retire cycle T gives imem_req=1 with the new address at T+1.
- ex_ready outside VALID is ignored. With ex_ready held low, ir/pc/ir_valid stay stable indefinitely.
- imem_rvalid outside WAIT is ignored: no capture, no state change.
- imem_addr only changes in the cycle after retire. It is stable while imem_req=1 and imem_ready=0.
- Reset asserted in WAIT abandons the request. A late imem_rvalid after reset arrives in REQ and is ignored.
- Wrap-around: pc_q=32'hFFFF_FFFC with pc_sel=0 gives next_pc=32'h0000_0000.
- Without the feature, next_pc[1:0] is forced to 2'b00 before loading pc_q.

Optional Feature:
- Macro: FETCH_MISALIGN_TRAP_EN.
- Defined:
  - If next_pc[1:0]!=0 at retire, load pc_q=next_pc unmasked, set fetch_misaligned=1, enter HALT.
  - HALT: imem_req=0, ir_valid=0, ir=NOP_INSN, pc=faulting target.
  - HALT is left only by reset.
- Undefined:
  - fetch_misaligned is tied to 0 and there is no HALT state.
  - Low two bits are masked as described in Behaviour.

Test Plan:
- Reset release, imem_ready=1, rvalid one cycle later, rdata=32'h0010_0093, ex_ready=1 -> imem_addr=0, then ir_valid=1 with ir=32'h0010_0093, pc=0, then imem_addr=4.
- pc_q=32'h100, pc_sel=1, imm=32'hFFFF_FFF0: br_taken=1 -> next imem_addr=32'hF0; br_taken=0 -> 32'h104.
- pc_sel=3, rs1_data=32'h2001, imm=32'h4 -> imem_addr=32'h2004 (bit0 cleared).
- ex_ready low for 10 cycles in VALID, rvalid pulsed during them -> ir/pc unchanged, no new imem_req. imem_ready low for 5 cycles in REQ -> imem_addr stable.
- Reset pulsed in WAIT, then rvalid arrives the cycle after release -> ignored, fetch restarts at RESET_PC, ir_valid=0 until a fresh response.
- With FETCH_MISALIGN_TRAP_EN, pc_sel=2, pc=0, imm=32'h6 -> fetch_misaligned=1, pc=32'h6, imem_req stays 0. Without the macro -> imem_addr=32'h4.
